// File: rtl/mpu_input_debounce.sv
// mpu_input_debounce
//   Front-panel conditioning for the MPU clock divider. Synchronises and
//   debounces the run/stop switch and the single-step pushbutton, producing
//   a debounced run level, a debounced step level, and a one-clock step pulse
//   per accepted press. With REPEAT_EN set, a held step button also produces
//   a pulse stream: the first repeat comes HOLD_CYCLES after acceptance, and
//   later ones come every REPEAT_CYCLES.
// Ports:
//   clk          in   system clock, all state on rising edge
//   rst          in   asynchronous active-high reset
//   sw_run_raw   in   raw run/stop switch (asynchronous)
//   btn_step_raw in   raw step pushbutton (asynchronous)
//   clk_en       out  debounced run level
//   step_press   out  one-clock pulse per accepted press / repeat
//   step_held    out  debounced step level

// Per-channel optional inversion, 2-flop synchroniser and debounce counter.
// rise_o/fall_o flag the edge on which level_o is about to change, so the
// caller can act in the same clock that the level updates.
module mpu_input_debounce_chan #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          INVERT          = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i ^ INVERT;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
      accept   = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign level_o = stable_q;
  assign rise_o  = accept & sync2_q;
  assign fall_o  = accept & ~sync2_q;
endmodule

module mpu_input_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_EN       = 0,
  parameter int unsigned HOLD_CYCLES     = 25000000,
  parameter int unsigned REPEAT_CYCLES   = 5000000,
  parameter int unsigned ACTIVE_LOW      = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_run_raw,
  input  logic btn_step_raw,
  output logic clk_en,
  output logic step_press,
  output logic step_held
);
  localparam int unsigned RMAX   = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned RCNT_W = $clog2(RMAX) + 1;
  localparam logic [RCNT_W-1:0] HOLD_LAST = RCNT_W'(HOLD_CYCLES - 1);
  localparam logic [RCNT_W-1:0] REP_LAST  = RCNT_W'(REPEAT_CYCLES - 1);
  localparam bit INV     = (ACTIVE_LOW != 0);
  localparam bit REP_ON  = (REPEAT_EN != 0);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} state_e;

  state_e              state_q, state_d;
  logic [RCNT_W-1:0]   rcnt_q, rcnt_d;
  logic                step_press_q, step_press_d;
  logic                rep_pulse;
  logic                run_rise, run_fall;
  logic                step_rise, step_fall;

  mpu_input_debounce_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .INVERT         (INV)
  ) u_run (
    .clk    (clk),
    .rst    (rst),
    .raw_i  (sw_run_raw),
    .level_o(clk_en),
    .rise_o (run_rise),
    .fall_o (run_fall)
  );

  mpu_input_debounce_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .INVERT         (INV)
  ) u_step (
    .clk    (clk),
    .rst    (rst),
    .raw_i  (btn_step_raw),
    .level_o(step_held),
    .rise_o (step_rise),
    .fall_o (step_fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rcnt_q       <= '0;
      step_press_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rcnt_q       <= rcnt_d;
      step_press_q <= step_press_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    rep_pulse = 1'b0;
    case (state_q)
      S_IDLE: begin
        rcnt_d = '0;
        if (step_rise && REP_ON) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (rcnt_q == HOLD_LAST) begin
          rep_pulse = 1'b1;
          rcnt_d    = '0;
          state_d   = S_REPEAT;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      S_REPEAT: begin
        if (rcnt_q == REP_LAST) begin
          rep_pulse = 1'b1;
          rcnt_d    = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        rcnt_d  = '0;
      end
    endcase
    // Release wins over any repeat pulse due on the same clock.
    if (step_fall) begin
      state_d   = S_IDLE;
      rcnt_d    = '0;
      rep_pulse = 1'b0;
    end
    // Masking against the previous pulse keeps step_press from ever being
    // high on two consecutive clocks, even with degenerate HOLD_CYCLES.
    step_press_d = step_rise | (rep_pulse & ~step_press_q);
  end

  assign step_press = step_press_q;

  // Run-channel edge flags are not needed beyond the level itself.
  logic unused_run;
  assign unused_run = run_rise ^ run_fall;
endmodule

// File: tb/tb_mpu_input_debounce.sv
module tb_mpu_input_debounce;
  logic clk = 1'b0;
  logic rst = 1'b1;

  logic r0_run = 1'b0, r0_btn = 1'b0;
  logic r1_run = 1'b0, r1_btn = 1'b0;
  logic r2_run = 1'b1, r2_btn = 1'b1;
  logic en0, press0, held0;
  logic en1, press1, held1;
  logic en2, press2, held2;

  int tests = 0;
  int fails = 0;
  int press_cnt0 = 0, press_cnt1 = 0, press_cnt2 = 0;
  int consec = 0;
  logic prev0 = 1'b0, prev1 = 1'b0, prev2 = 1'b0;

  always #5 clk = ~clk;

  mpu_input_debounce #(
    .DEBOUNCE_CYCLES(8), .REPEAT_EN(0), .HOLD_CYCLES(20), .REPEAT_CYCLES(6), .ACTIVE_LOW(0)
  ) dut0 (
    .clk(clk), .rst(rst), .sw_run_raw(r0_run), .btn_step_raw(r0_btn),
    .clk_en(en0), .step_press(press0), .step_held(held0)
  );

  mpu_input_debounce #(
    .DEBOUNCE_CYCLES(8), .REPEAT_EN(1), .HOLD_CYCLES(20), .REPEAT_CYCLES(6), .ACTIVE_LOW(0)
  ) dut1 (
    .clk(clk), .rst(rst), .sw_run_raw(r1_run), .btn_step_raw(r1_btn),
    .clk_en(en1), .step_press(press1), .step_held(held1)
  );

  mpu_input_debounce #(
    .DEBOUNCE_CYCLES(8), .REPEAT_EN(0), .HOLD_CYCLES(20), .REPEAT_CYCLES(6), .ACTIVE_LOW(1)
  ) dut2 (
    .clk(clk), .rst(rst), .sw_run_raw(r2_run), .btn_step_raw(r2_btn),
    .clk_en(en2), .step_press(press2), .step_held(held2)
  );

  always @(negedge clk) begin
    if (press0) press_cnt0++;
    if (press1) press_cnt1++;
    if (press2) press_cnt2++;
    if ((press0 && prev0) || (press1 && prev1) || (press2 && prev2)) consec++;
    prev0 = press0;
    prev1 = press1;
    prev2 = press2;
  end

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step(2);
    tests++; if ({en0, press0, held0} !== 3'b000) begin fails++; $display("FAIL reset_dut0: outputs=%b expected 000", {en0, press0, held0}); end
    tests++; if ({en1, press1, held1} !== 3'b000) begin fails++; $display("FAIL reset_dut1: outputs=%b expected 000", {en1, press1, held1}); end
    tests++; if ({en2, press2, held2} !== 3'b000) begin fails++; $display("FAIL reset_dut2: outputs=%b expected 000", {en2, press2, held2}); end
    rst = 1'b0;
    step(12);
    tests++; if ({en2, press2, held2} !== 3'b000) begin fails++; $display("FAIL active_low_idle: outputs=%b expected 000", {en2, press2, held2}); end
  endtask

  task automatic test_clean_run;
    int p;
    p = press_cnt0;
    r0_run = 1'b1;
    step(9);
    tests++; if (en0 !== 1'b0) begin fails++; $display("FAIL clean_rise_early: clk_en=%b expected 0", en0); end
    step(1);
    tests++; if (en0 !== 1'b1) begin fails++; $display("FAIL clean_rise: clk_en=%b expected 1", en0); end
    step(5);
    r0_run = 1'b0;
    step(9);
    tests++; if (en0 !== 1'b1) begin fails++; $display("FAIL clean_fall_early: clk_en=%b expected 1", en0); end
    step(1);
    tests++; if (en0 !== 1'b0) begin fails++; $display("FAIL clean_fall: clk_en=%b expected 0", en0); end
    step(2);
    tests++; if (press_cnt0 !== p) begin fails++; $display("FAIL clean_no_press: presses=%0d expected %0d", press_cnt0, p); end
  endtask

  task automatic test_bounce;
    int p;
    p = press_cnt0;
    r0_btn = 1'b1; step(3);
    r0_btn = 1'b0; step(3);
    r0_btn = 1'b1;
    step(9);
    tests++; if ({held0, press0} !== 2'b00) begin fails++; $display("FAIL bounce_early: held/press=%b expected 00", {held0, press0}); end
    step(1);
    tests++; if ({held0, press0} !== 2'b11) begin fails++; $display("FAIL bounce_accept: held/press=%b expected 11", {held0, press0}); end
    step(1);
    tests++; if ({held0, press0} !== 2'b10) begin fails++; $display("FAIL bounce_pulse_width: held/press=%b expected 10", {held0, press0}); end
    step(30);
    tests++; if (press_cnt0 !== p + 1) begin fails++; $display("FAIL bounce_single_press: presses=%0d expected %0d", press_cnt0, p + 1); end
    r0_btn = 1'b0;
    step(12);
    tests++; if (held0 !== 1'b0) begin fails++; $display("FAIL bounce_release: held=%b expected 0", held0); end
    tests++; if (press_cnt0 !== p + 1) begin fails++; $display("FAIL release_no_press: presses=%0d expected %0d", press_cnt0, p + 1); end
  endtask

  task automatic test_glitch;
    int bad;
    bad = 0;
    r0_run = 1'b1; step(7);
    r0_run = 1'b0;
    for (int k = 0; k < 15; k++) begin
      step(1);
      if (en0 !== 1'b0) bad++;
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL glitch_7: cycles with clk_en=1 was %0d expected 0", bad); end
    // Exactly DEBOUNCE_CYCLES samples is the shortest accepted pulse.
    r0_run = 1'b1; step(8);
    r0_run = 1'b0;
    step(1);
    tests++; if (en0 !== 1'b0) begin fails++; $display("FAIL pulse8_early: clk_en=%b expected 0", en0); end
    step(1);
    tests++; if (en0 !== 1'b1) begin fails++; $display("FAIL pulse8_accept: clk_en=%b expected 1", en0); end
    step(7);
    tests++; if (en0 !== 1'b1) begin fails++; $display("FAIL pulse8_hold: clk_en=%b expected 1", en0); end
    step(1);
    tests++; if (en0 !== 1'b0) begin fails++; $display("FAIL pulse8_fall: clk_en=%b expected 0", en0); end
  endtask

  task automatic test_auto_repeat;
    logic exp_p, exp_h;
    r1_btn = 1'b1;
    step(10);
    tests++; if ({held1, press1} !== 2'b11) begin fails++; $display("FAIL repeat_accept: held/press=%b expected 11", {held1, press1}); end
    for (int k = 1; k <= 90; k++) begin
      step(1);
      exp_p = (k >= 20 && k <= 68 && ((k - 20) % 6) == 0);
      exp_h = (k < 70);
      tests++; if (press1 !== exp_p) begin fails++; $display("FAIL repeat_press k=%0d: press=%b expected %b", k, press1, exp_p); end
      tests++; if (held1 !== exp_h) begin fails++; $display("FAIL repeat_held k=%0d: held=%b expected %b", k, held1, exp_h); end
      if (k == 60) r1_btn = 1'b0;
    end
    // A fresh press must restart from the full hold time.
    r1_btn = 1'b1;
    step(10);
    tests++; if (press1 !== 1'b1) begin fails++; $display("FAIL repress_accept: press=%b expected 1", press1); end
    for (int k = 1; k <= 21; k++) begin
      step(1);
      exp_p = (k == 20);
      tests++; if (press1 !== exp_p) begin fails++; $display("FAIL repress_press k=%0d: press=%b expected %b", k, press1, exp_p); end
    end
    r1_btn = 1'b0;
    step(12);
  endtask

  task automatic test_active_low;
    int p;
    p = press_cnt2;
    r2_btn = 1'b0;
    step(9);
    tests++; if ({held2, press2} !== 2'b00) begin fails++; $display("FAIL al_early: held/press=%b expected 00", {held2, press2}); end
    step(1);
    tests++; if ({held2, press2} !== 2'b11) begin fails++; $display("FAIL al_accept: held/press=%b expected 11", {held2, press2}); end
    step(5);
    tests++; if (press_cnt2 !== p + 1) begin fails++; $display("FAIL al_count: presses=%0d expected %0d", press_cnt2, p + 1); end
    tests++; if (en2 !== 1'b0) begin fails++; $display("FAIL al_run_idle: clk_en=%b expected 0", en2); end
  endtask

  task automatic test_async_reset;
    r0_run = 1'b1;
    r0_btn = 1'b1;
    step(12);
    tests++; if ({en0, held0} !== 2'b11) begin fails++; $display("FAIL prereset_levels: en/held=%b expected 11", {en0, held0}); end
    #3;
    rst = 1'b1;
    #1;
    tests++; if ({en0, press0, held0} !== 3'b000) begin fails++; $display("FAIL async_reset: outputs=%b expected 000", {en0, press0, held0}); end
    step(3);
    rst = 1'b0;
    step(9);
    tests++; if ({en0, press0, held0} !== 3'b000) begin fails++; $display("FAIL postreset_early: outputs=%b expected 000", {en0, press0, held0}); end
    step(1);
    tests++; if ({en0, press0, held0} !== 3'b111) begin fails++; $display("FAIL postreset_accept: outputs=%b expected 111", {en0, press0, held0}); end
  endtask

  initial begin
    test_reset;
    test_clean_run;
    test_bounce;
    test_glitch;
    test_auto_repeat;
    test_active_low;
    test_async_reset;
    step(2);
    tests++; if (consec !== 0) begin fails++; $display("FAIL press_consecutive: count=%0d expected 0", consec); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
